// File: rtl/fetch_controller.sv
// IF-stage sequencer: PC advance/select, IF/ID load/flush/hold, ID/EX bubble, halt.
// Outputs are Mealy (same cycle); optional saturating perf counters under FETCH_PERF_EN.
module fetch_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IM_Ready,
    input  logic             BranchResult_in,
    input  logic             JumpControl_in,
    input  logic             LoadUse_in,
    input  logic             Halt_in,
    output logic             PCWrite_out,
    output logic [1:0]       PCSel_out,
    output logic             IFID_Write_out,
    output logic             IFID_Flush_out,
    output logic             IDEX_Bubble_out,
    output logic             Halted_out,
    output logic [CNT_W-1:0] StallCount_out,
    output logic [CNT_W-1:0] RedirectCount_out
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_RUN     = 3'd1,
        S_FLUSH   = 3'd2,
        S_MEMWAIT = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic [1:0] pend_sel, pend_sel_nxt;
    logic       redir;
    logic [1:0] redir_sel;
    logic [1:0] eff_sel;

    assign redir     = JumpControl_in | BranchResult_in;
    assign redir_sel = JumpControl_in ? SEL_JMP : (BranchResult_in ? SEL_BR : SEL_SEQ);
    // A redirect arriving while waiting replaces whatever was pending.
    assign eff_sel   = redir ? redir_sel : pend_sel;

    always_comb begin
        PCWrite_out     = 1'b0;
        PCSel_out       = SEL_SEQ;
        IFID_Write_out  = 1'b0;
        IFID_Flush_out  = 1'b0;
        IDEX_Bubble_out = 1'b0;
        Halted_out      = 1'b0;
        state_nxt       = state;
        flush_cnt_nxt   = flush_cnt;
        pend_sel_nxt    = pend_sel;

        case (state)
            S_RUN: begin
                if (Halt_in) begin
                    IFID_Flush_out = 1'b1;
                    state_nxt      = S_HALT;
                end else if (redir) begin
                    IFID_Flush_out = 1'b1;
                    if (IM_Ready) begin
                        PCWrite_out   = 1'b1;
                        PCSel_out     = redir_sel;
                        state_nxt     = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end else begin
                        pend_sel_nxt = redir_sel;
                        state_nxt    = S_MEMWAIT;
                    end
                end else if (LoadUse_in) begin
                    IDEX_Bubble_out = 1'b1;
                end else if (!IM_Ready) begin
                    IFID_Flush_out = 1'b1;
                    state_nxt      = S_MEMWAIT;
                end else begin
                    PCWrite_out    = 1'b1;
                    IFID_Write_out = 1'b1;
                end
            end
            S_FLUSH: begin
                PCWrite_out    = IM_Ready;
                IFID_Flush_out = 1'b1;
                if (IM_Ready) begin
                    if (flush_cnt <= 3'd1) begin
                        flush_cnt_nxt = 3'd0;
                        state_nxt     = S_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                    end
                end
            end
            S_MEMWAIT: begin
                IFID_Flush_out = 1'b1;
                if (IM_Ready) begin
                    PCWrite_out  = 1'b1;
                    pend_sel_nxt = SEL_SEQ;
                    if (eff_sel != SEL_SEQ) begin
                        PCSel_out     = eff_sel;
                        state_nxt     = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end else begin
                        IFID_Flush_out = 1'b0;
                        IFID_Write_out = 1'b1;
                        state_nxt      = S_RUN;
                    end
                end else begin
                    pend_sel_nxt = eff_sel;
                end
            end
            S_HALT: begin
                IFID_Flush_out = 1'b1;
                Halted_out     = 1'b1;
            end
            default: begin
                IFID_Flush_out  = 1'b1;
                IDEX_Bubble_out = 1'b1;
                state_nxt       = S_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_INIT;
            flush_cnt <= 3'd0;
            pend_sel  <= SEL_SEQ;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            pend_sel  <= pend_sel_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    logic             stall_inc, redir_inc;
    logic [CNT_W-1:0] stall_cnt, redir_cnt;

    assign stall_inc = !PCWrite_out &&
                       (state == S_RUN || state == S_FLUSH || state == S_MEMWAIT);
    // Only a redirect ever loads the PC with a non-sequential select.
    assign redir_inc = PCWrite_out && (PCSel_out != SEL_SEQ);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redir_inc && (redir_cnt != '1))
                redir_cnt <= redir_cnt + 1'b1;
        end
    end

    assign StallCount_out    = stall_cnt;
    assign RedirectCount_out = redir_cnt;
`else
    assign StallCount_out    = '0;
    assign RedirectCount_out = '0;
`endif

endmodule
